// File: rtl/key_entry.sv
// Keypad entry stage for the xAyB game: builds a 4-digit BCD guess from key
// events and emits one-cycle command codes for the downstream game FSM.
module key_entry #(
  parameter logic [3:0] BLANK          = 4'hF,
  parameter bit         REQUIRE_UNIQUE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] value_out,
  output logic [2:0]  key_in_state,
  output logic [1:0]  key_in_mode,
  output logic        pressed,
  output logic [2:0]  digit_count
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_EDIT,
    S_CONFIRMED
  } state_t;

  typedef enum logic [2:0] {
    C_IDLE    = 3'd0,
    C_DIGIT   = 3'd1,
    C_REJECT  = 3'd2,
    C_BACK    = 3'd3,
    C_CLEAR   = 3'd4,
    C_CONFIRM = 3'd5,
    C_SUBMIT  = 3'd6,
    C_MODE    = 3'd7
  } code_t;

  localparam logic [3:0]  K_BACK    = 4'd10;
  localparam logic [3:0]  K_CONFIRM = 4'd11;
  localparam logic [3:0]  K_SUBMIT  = 4'd12;
  localparam logic [3:0]  K_MODE    = 4'd13;
  localparam logic [3:0]  K_CLEAR   = 4'd14;
  localparam logic [15:0] ALL_BLANK = {4{BLANK}};

  state_t      r_state;
  logic [15:0] r_buf;
  logic [2:0]  r_count;
  logic [15:0] r_value_out;
  logic [2:0]  r_disp_count;
  code_t       r_code;
  logic [1:0]  r_mode;
  logic        r_pressed;

  state_t      w_state_nx;
  logic [15:0] w_buf_nx;
  logic [2:0]  w_count_nx;
  code_t       w_code_nx;
  logic [1:0]  w_mode_nx;
  logic        w_hold_display;
  logic        w_dup;
  logic        w_distinct;

  // Incoming digit is compared only against filled positions (nibble 0 is newest).
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < r_count) && (r_buf[4*i +: 4] == key_code)) w_dup = 1'b1;
    end
  end

  always_comb begin
    w_distinct = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (r_buf[4*i +: 4] == r_buf[4*j +: 4]) w_distinct = 1'b0;
      end
    end
  end

  // NOTE: every output of this block is given a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nx     = r_state;
    w_buf_nx       = r_buf;
    w_count_nx     = r_count;
    w_code_nx      = C_IDLE;
    w_mode_nx      = r_mode;
    w_hold_display = 1'b0;

    if (key_valid) begin
      if (key_code <= 4'd9) begin
        if ((r_state != S_CONFIRMED) && (r_count < 3'd4) && !(REQUIRE_UNIQUE && w_dup)) begin
          w_buf_nx   = {r_buf[11:0], key_code};
          w_count_nx = r_count + 3'd1;
          w_state_nx = S_EDIT;
          w_code_nx  = C_DIGIT;
        end else begin
          w_code_nx  = C_REJECT;
        end
      end else begin
        case (key_code)
          K_BACK: begin
            if (r_count != 3'd0) begin
              w_buf_nx   = {BLANK, r_buf[15:4]};
              w_count_nx = r_count - 3'd1;
              w_state_nx = (r_count == 3'd1) ? S_EMPTY : S_EDIT;
              w_code_nx  = C_BACK;
            end else begin
              w_code_nx  = C_REJECT;
            end
          end
          K_CONFIRM: begin
            if ((r_count == 3'd4) && (!REQUIRE_UNIQUE || w_distinct)) begin
              w_state_nx = S_CONFIRMED;
              w_code_nx  = C_CONFIRM;
            end else begin
              w_code_nx  = C_REJECT;
            end
          end
          K_SUBMIT: begin
            // The confirmed value stays on value_out while code 6 is shown.
            if (r_state == S_CONFIRMED) begin
              w_buf_nx       = ALL_BLANK;
              w_count_nx     = 3'd0;
              w_state_nx     = S_EMPTY;
              w_code_nx      = C_SUBMIT;
              w_hold_display = 1'b1;
            end else begin
              w_code_nx      = C_REJECT;
            end
          end
          K_MODE: begin
            w_mode_nx = (r_mode == 2'd2) ? 2'd0 : r_mode + 2'd1;
            w_code_nx = C_MODE;
          end
          K_CLEAR: begin
            w_buf_nx   = ALL_BLANK;
            w_count_nx = 3'd0;
            w_state_nx = S_EMPTY;
            w_code_nx  = C_CLEAR;
          end
          default: w_code_nx = C_IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_buf        <= ALL_BLANK;
      r_count      <= 3'd0;
      r_value_out  <= ALL_BLANK;
      r_disp_count <= 3'd0;
      r_code       <= C_IDLE;
      r_mode       <= 2'd0;
      r_pressed    <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_buf        <= w_buf_nx;
      r_count      <= w_count_nx;
      r_value_out  <= w_hold_display ? r_value_out  : w_buf_nx;
      r_disp_count <= w_hold_display ? r_disp_count : w_count_nx;
      r_code       <= w_code_nx;
      r_mode       <= w_mode_nx;
      r_pressed    <= key_valid;
    end
  end

  assign value_out    = r_value_out;
  assign digit_count  = r_disp_count;
  assign key_in_state = r_code;
  assign key_in_mode  = r_mode;
  assign pressed      = r_pressed;

endmodule

// File: tb/tb_key_entry.sv
// Scoreboard bench for key_entry: a digit-list reference model predicts each
// key's response; an independent monitor compares every cycle.
module tb_key_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [15:0] value_out;
  logic [2:0]  key_in_state;
  logic [1:0]  key_in_mode;
  logic        pressed;
  logic [2:0]  digit_count;

  key_entry dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .value_out    (value_out),
    .key_in_state (key_in_state),
    .key_in_mode  (key_in_mode),
    .pressed      (pressed),
    .digit_count  (digit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pulse_value;
    logic [2:0]  pulse_count;
    logic [2:0]  code;
    logic [1:0]  mode;
    logic [15:0] settled_value;
    logic [2:0]  settled_count;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: the entry is a list of digits, oldest first.
  int digits[$];
  bit confirmed;
  int mode_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] shown();
    logic [15:0] v = 16'hFFFF;
    foreach (digits[i]) v = {v[11:0], 4'(digits[i])};
    return v;
  endfunction

  function automatic bit holds(input int d);
    foreach (digits[i]) if (digits[i] == d) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit all_distinct();
    foreach (digits[i])
      for (int j = i + 1; j < digits.size(); j++)
        if (digits[i] == digits[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    digits.delete();
    confirmed = 1'b0;
    mode_m    = 0;
  endtask

  task automatic apply_key(input int k);
    exp_t        e;
    int          c;
    logic [15:0] old_v = shown();
    int          old_n = digits.size();
    bit          submitted = 1'b0;
    if (k <= 9) begin
      if (!confirmed && digits.size() < 4 && !holds(k)) begin
        digits.push_back(k);
        c = 1;
      end else c = 2;
    end else begin
      case (k)
        10: if (digits.size() > 0) begin
              void'(digits.pop_back());
              confirmed = 1'b0;
              c = 3;
            end else c = 2;
        11: if (digits.size() == 4 && all_distinct()) begin
              confirmed = 1'b1;
              c = 5;
            end else c = 2;
        12: if (confirmed) begin
              digits.delete();
              confirmed = 1'b0;
              submitted = 1'b1;
              c = 6;
            end else c = 2;
        13: begin mode_m = (mode_m + 1) % 3; c = 7; end
        14: begin digits.delete(); confirmed = 1'b0; c = 4; end
        default: c = 0;
      endcase
    end
    e.code          = 3'(c);
    e.mode          = 2'(mode_m);
    e.settled_value = shown();
    e.settled_count = 3'(digits.size());
    e.pulse_value   = submitted ? old_v : e.settled_value;
    e.pulse_count   = submitted ? 3'(old_n) : e.settled_count;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit v, input int k, input bit r);
    @(negedge clk);
    rst       = r;
    key_valid = v;
    key_code  = 4'(k);
    if (r) model_reset();
    else if (v) apply_key(k);
  endtask

  task automatic keys(input int ks[$]);
    foreach (ks[i]) drive(1'b1, ks[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
  endtask

  // Monitor: one comparison set per cycle, decoupled from the driver.
  initial begin
    logic [15:0] s_val;
    logic [2:0]  s_cnt;
    logic [1:0]  s_mode;
    logic        rst_s;
    exp_t        e;
    s_val  = 16'hFFFF;
    s_cnt  = 3'd0;
    s_mode = 2'd0;
    forever begin
      @(posedge clk);
      rst_s = rst;
      #1;
      if (rst_s) begin
        check("rst_pressed", 32'(pressed), 32'd0);
        check("rst_code",    32'(key_in_state), 32'd0);
        check("rst_value",   32'(value_out), 32'hFFFF);
        check("rst_mode",    32'(key_in_mode), 32'd0);
        check("rst_count",   32'(digit_count), 32'd0);
        s_val  = 16'hFFFF;
        s_cnt  = 3'd0;
        s_mode = 2'd0;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("key_pressed", 32'(pressed), 32'd1);
        check("key_code",    32'(key_in_state), 32'(e.code));
        check("key_value",   32'(value_out), 32'(e.pulse_value));
        check("key_count",   32'(digit_count), 32'(e.pulse_count));
        check("key_mode",    32'(key_in_mode), 32'(e.mode));
        s_val  = e.settled_value;
        s_cnt  = e.settled_count;
        s_mode = e.mode;
      end else begin
        check("idle_pressed", 32'(pressed), 32'd0);
        check("idle_code",    32'(key_in_state), 32'd0);
        check("idle_value",   32'(value_out), 32'(s_val));
        check("idle_count",   32'(digit_count), 32'(s_cnt));
        check("idle_mode",    32'(key_in_mode), 32'(s_mode));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int k;
    model_reset();
    drive(1'b0, 0, 1'b1);
    drive(1'b0, 0, 1'b1);
    idle(2);

    // Entry, confirm, submit, with confirm reissue.
    keys('{1, 2, 3, 4, 11, 11, 12});
    idle(2);
    // Duplicate and overflow.
    keys('{5, 5, 6, 7, 8, 9, 14});
    idle(1);
    // Backspace down to empty and one past.
    keys('{1, 2, 3, 4, 10, 10, 10, 10, 10});
    idle(1);
    // Submit gating and digit in CONFIRMED.
    keys('{1, 2, 3, 12, 4, 12, 11, 7, 12});
    idle(2);
    // Mode cycling and no-op.
    keys('{13, 13, 13, 13, 15, 15});
    idle(1);
    // Reset beats a digit in the same cycle.
    keys('{9, 1, 2});
    drive(1'b1, 3, 1'b1);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) drive(1'b1, $urandom_range(0, 15), 1'b1);
      else if (r < 25) idle(1);
      else begin
        k = ($urandom_range(0, 99) < 55) ? $urandom_range(0, 9) : $urandom_range(10, 15);
        drive(1'b1, k, 1'b0);
      end
    end
    idle(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
